dt_sti_loader: RTL and testbench
================================

Name: dt_sti_loader

Overview:
- Sequencer for the distance-transform datapath that performs the image-load phase.
- Reads packed binary image words from the stimulus ROM (1024 x 16 bit, 16 pixels per word) and writes one 8-bit pixel per cycle into the result RAM (16384 x 8 bit).
- The result is the initial 0/foreground map that the forward pass consumes.
- A `hold` input lets a higher-level arbiter take the RAM port without losing loader state.

Parameters:
- WORDS, 1024, number of ROM words to load; word address width is 10.
- PIX_W, 8, result RAM data width.
- FG_VAL, 1, value written for a set (foreground) pixel; background always writes 0.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- hold  input  1  arbiter stall; while high, no ROM read or RAM write is issued and state freezes.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse after the last pixel is written.
- sti_rd  output  1  ROM read enable.
- sti_addr  output  10  ROM word address.
- sti_di  input  16  ROM data; registered by the ROM on falling edge, valid at the next rising edge.
- res_wr  output  1  RAM write enable; RAM writes on rising edge.
- res_addr  output  14  RAM pixel address.
- res_do  output  PIX_W  RAM write data.

Behaviour:
- Interface: one clock, `clk`; `reset` is synchronous and active-high.
- Reset: all outputs 0, FSM in IDLE, word counter w=0, bit counter k=0, word buffer 0. Reset mid-load aborts immediately; no further reads or writes, and no done.
- States:
  - IDLE -> FETCH on start=1; w=0.
  - FETCH: sti_rd=1, sti_addr=w. If hold=1, sti_rd=0 and the FSM stays in FETCH. Otherwise latch sti_di into buf at the cycle-ending edge, set k=0, go to WRITE.
  - WRITE: res_wr=1, res_addr={w,k[3:0]} (= w*16+k), res_do = buf[15-k] ? FG_VAL : 0. Bit 15 of each word is the leftmost pixel.
    - If hold=1: res_wr=0 and k frozen.
    - At k=15 (not held): if w==WORDS-1 go to DONE, else w=w+1 and go to FETCH.
  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: 17 cycles per word without hold. Full image: 1024*17=17408 cycles from the first FETCH to the last write; done asserts the following cycle.
- start while busy: ignored. start in the same cycle as reset: reset wins.
- hold asserted in any state other than FETCH/WRITE: no effect.
- Outputs are registered-free combinational decodes of the state/counters, except done and busy, which are registered.
- res_do is 0 whenever res_wr=0.
- No RAM reads are issued; res_rd is owned elsewhere.

Optional Feature:
- Macro: DT_LOADER_SKIP_ZERO_EN.
- Enabled: the RAM is assumed pre-cleared.
  - Background pixels are not written: res_wr=0 for that k, and k still advances.
  - A latched word equal to 16'h0000 skips WRITE entirely: FETCH -> FETCH with w+1, or -> DONE if it was the last word.
  - The final RAM contents are identical to the disabled case; cycle count drops.
- Disabled: every pixel is written; fixed 17 cycles/word.

Test Plan:
- Single word: ROM[0]=16'h8001, WORDS=1, start pulse -> RAM[0]=01, RAM[1..14]=00, RAM[15]=01; done exactly 18 cycles after start is sampled; busy high throughout.
- Full 1024-word Geometry image -> RAM matches the expected 0/1 expansion for all 16384 addresses; done exactly once; busy low afterwards.
- Hold: assert hold for 5 cycles at k=7 of word 3 -> no res_wr during hold, RAM[55] written once after release; total time +5 cycles.
- Reset mid-load at w=100: writes stop the same cycle, done never pulses; a new start reloads from w=0 correctly.
- start pulsed while busy at w=10 -> ignored; the load completes in 17408+1 cycles, not restarted.
- With DT_LOADER_SKIP_ZERO_EN, ROM all-zero except ROM[5]=16'hFFFF -> exactly 16 writes (addr 80..95, data 01), done after 1024+16+1 cycles.

Source files
------------

// File: rtl/dt_sti_loader.sv
// dt_sti_loader: image-load sequencer that expands packed ROM words into one pixel per RAM write.
// Optional macro DT_LOADER_SKIP_ZERO_EN: skip background writes and all-zero words (RAM assumed pre-cleared).
module dt_sti_loader #(
   parameter int WORDS  = 1024,
   parameter int PIX_W  = 8,
   parameter int FG_VAL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic             sti_rd,
   output logic [9:0]       sti_addr,
   input  logic [15:0]      sti_di,
   output logic             res_wr,
   output logic [13:0]      res_addr,
   output logic [PIX_W-1:0] res_do
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

   localparam logic [9:0] LAST_W = 10'(WORDS - 1);

   state_t      state, state_nx;
   logic [9:0]  w;
   logic [3:0]  k;
   logic [15:0] word_buf;
   logic        last_word;
   logic        pix;
   logic        skip_word;

   assign last_word = (w == LAST_W);
   assign pix       = word_buf[4'd15 - k];

`ifdef DT_LOADER_SKIP_ZERO_EN
   assign skip_word = (sti_di == '0);
`else
   assign skip_word = 1'b0;
`endif

   // Counters live with the state register; busy/done are registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         w        <= '0;
         k        <= '0;
         word_buf <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx == S_FETCH) || (state_nx == S_WRITE);
         done  <= (state_nx == S_DONE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  w <= '0;
                  k <= '0;
               end
            end
            S_FETCH: begin
               if (!hold) begin
                  word_buf <= sti_di;
                  k        <= '0;
                  if (skip_word && !last_word)
                     w <= w + 10'd1;
               end
            end
            S_WRITE: begin
               if (!hold) begin
                  k <= k + 4'd1;
                  if (k == 4'd15 && !last_word)
                     w <= w + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start)
               state_nx = S_FETCH;
         end
         S_FETCH: begin
            if (!hold) begin
               if (skip_word)
                  state_nx = last_word ? S_DONE : S_FETCH;
               else
                  state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!hold && k == 4'd15)
               state_nx = last_word ? S_DONE : S_FETCH;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Strobes are also gated by reset so an abort suppresses the access in the reset cycle itself.
   always_comb begin
      sti_rd   = 1'b0;
      sti_addr = '0;
      res_wr   = 1'b0;
      res_addr = '0;
      res_do   = '0;
      case (state)
         S_FETCH: begin
            sti_addr = w;
            sti_rd   = !hold && !reset;
         end
         S_WRITE: begin
            res_addr = {w, k};
`ifdef DT_LOADER_SKIP_ZERO_EN
            res_wr   = !hold && !reset && pix;
`else
            res_wr   = !hold && !reset;
`endif
            if (res_wr && pix)
               res_do = PIX_W'(FG_VAL);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dt_sti_loader.sv
// Self-checking bench for dt_sti_loader: write scoreboard, RAM/ROM models, timing and control scenarios.
module tb_dt_sti_loader;

`ifdef DT_LOADER_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   localparam int LIMIT = 40000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clr;
   logic        b_start, b_hold, b_busy, b_done, b_sti_rd, b_res_wr;
   logic [9:0]  b_sti_addr;
   logic [15:0] b_sti_di;
   logic [13:0] b_res_addr;
   logic [7:0]  b_res_do;
   logic        s_start, s_hold, s_busy, s_done, s_sti_rd, s_res_wr;
   logic [9:0]  s_sti_addr;
   logic [15:0] s_sti_di;
   logic [13:0] s_res_addr;
   logic [7:0]  s_res_do;

   logic [15:0] rom   [0:1023];
   logic [7:0]  ram_b [0:16383];
   int          wcnt_b[0:16383];
   logic [7:0]  ram_s [0:15];
   logic [21:0] q_b[$];
   logic [21:0] q_s[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          done_b = 0;
   int          done_s = 0;

   dt_sti_loader #(.WORDS(1024), .PIX_W(8), .FG_VAL(1)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .hold(b_hold), .busy(b_busy), .done(b_done),
      .sti_rd(b_sti_rd), .sti_addr(b_sti_addr), .sti_di(b_sti_di),
      .res_wr(b_res_wr), .res_addr(b_res_addr), .res_do(b_res_do));

   dt_sti_loader #(.WORDS(1), .PIX_W(8), .FG_VAL(1)) dut_s (
      .clk(clk), .reset(reset), .start(s_start), .hold(s_hold), .busy(s_busy), .done(s_done),
      .sti_rd(s_sti_rd), .sti_addr(s_sti_addr), .sti_di(s_sti_di),
      .res_wr(s_res_wr), .res_addr(s_res_addr), .res_do(s_res_do));

   // ROM registers its output on the falling edge of a read cycle.
   always @(negedge clk) begin
      if (b_sti_rd) b_sti_di <= rom[b_sti_addr];
      if (s_sti_rd) s_sti_di <= rom[s_sti_addr];
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 16384; i++) begin
            ram_b[i]  <= 8'd0;
            wcnt_b[i] <= 0;
         end
         for (int i = 0; i < 16; i++) ram_s[i] <= 8'd0;
      end else begin
         if (b_res_wr) begin
            ram_b[b_res_addr]  <= b_res_do;
            wcnt_b[b_res_addr] <= wcnt_b[b_res_addr] + 1;
         end
         if (s_res_wr && s_res_addr < 14'd16) ram_s[s_res_addr[3:0]] <= s_res_do;
      end
   end

   function automatic logic [15:0] geo_word(input int w);
      logic [15:0] v;
      int x, y;
      v = '0;
      y = w / 8;
      for (int b = 0; b < 16; b++) begin
         x = (w % 8) * 16 + 15 - b;
         if (y < 2 || x == y ||
             (x >= 20 && x < 100 && y >= 30 && y < 90 && !(x >= 40 && x < 80 && y >= 50 && y < 70)))
            v[b] = 1'b1;
      end
      return v;
   endfunction

   function automatic int exp_cycles(input int words);
      int n;
      n = 1;
      for (int w = 0; w < words; w++) n += (SKIP && rom[w] == 16'h0000) ? 1 : 17;
      return n;
   endfunction

   function automatic int ram_errs_b();
      int e;
      logic [15:0] word;
      e = 0;
      for (int a = 0; a < 16384; a++) begin
         word = rom[a / 16];
         if (ram_b[a] !== {7'd0, word[15 - (a % 16)]}) e++;
      end
      return e;
   endfunction

   task automatic push_exp(input int words, input bit to_small);
      logic [15:0] word;
      for (int w = 0; w < words; w++) begin
         word = rom[w];
         for (int k = 0; k < 16; k++) begin
            if (!SKIP || word[15 - k]) begin
               if (to_small) q_s.push_back({14'(w * 16 + k), 7'd0, word[15 - k]});
               else          q_b.push_back({14'(w * 16 + k), 7'd0, word[15 - k]});
            end
         end
      end
   endtask

   task automatic clear_ram();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
   endtask

   task automatic pulse_b_start();
      @(posedge clk); #1 b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
   endtask

   task automatic wait_b(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b_done && n < LIMIT);
   endtask

   // Scoreboard: every DUT write is popped against the expectation queued at start time.
   task automatic monitor();
      logic [21:0] e;
      forever begin
         @(negedge clk);
         if (b_done) done_b++;
         if (s_done) done_s++;
         n_chk++;
         if (b_res_wr) begin
            if (q_b.size() == 0) begin
               n_fail++;
               $display("FAIL b_write: got addr=%0d data=%0d, required no write", b_res_addr, b_res_do);
            end else begin
               e = q_b.pop_front();
               if ({b_res_addr, b_res_do} !== e) begin
                  n_fail++;
                  $display("FAIL b_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                           b_res_addr, b_res_do, e[21:8], e[7:0]);
               end
            end
         end else if (b_res_do !== 8'd0) begin
            n_fail++;
            $display("FAIL b_idle_data: got res_do=%0d, required 0", b_res_do);
         end
         n_chk++;
         if (s_res_wr) begin
            if (q_s.size() == 0) begin
               n_fail++;
               $display("FAIL s_write: got addr=%0d data=%0d, required no write", s_res_addr, s_res_do);
            end else begin
               e = q_s.pop_front();
               if ({s_res_addr, s_res_do} !== e) begin
                  n_fail++;
                  $display("FAIL s_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                           s_res_addr, s_res_do, e[21:8], e[7:0]);
               end
            end
         end else if (s_res_do !== 8'd0) begin
            n_fail++;
            $display("FAIL s_idle_data: got res_do=%0d, required 0", s_res_do);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({b_busy, b_done, b_sti_rd, b_sti_addr, b_res_wr, b_res_addr, b_res_do} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_b: got busy=%b done=%b rd=%b saddr=%0d wr=%b raddr=%0d do=%0d, required all 0",
                  b_busy, b_done, b_sti_rd, b_sti_addr, b_res_wr, b_res_addr, b_res_do);
      end
      n_chk++;
      if ({s_busy, s_done, s_sti_rd, s_sti_addr, s_res_wr, s_res_addr, s_res_do} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_s: got busy=%b done=%b rd=%b, required all 0", s_busy, s_done, s_sti_rd);
      end
      @(posedge clk); #1 reset = 1'b0; b_start = 1'b0; s_start = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({b_busy, s_busy, b_sti_rd, s_sti_rd} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_wins_start: got busy=%b%b rd=%b%b, required 0000", b_busy, s_busy, b_sti_rd, s_sti_rd);
      end
   endtask

   task automatic test_single_word();
      int n;
      bit got;
      int mid;
      rom[0] = 16'h8001;
      clear_ram();
      q_s.delete();
      push_exp(1, 1'b1);
      @(posedge clk); #1 s_start = 1'b1;
      @(posedge clk); #1 s_start = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         n_chk++;
         if (s_done) begin
            got = 1'b1;
            if (s_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL single_busy_at_done: got %b, required 0", s_busy);
            end
         end else if (s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: cycle %0d got %b, required 1", n, s_busy);
         end
      end
      n_chk++;
      if (n !== 18) begin
         n_fail++;
         $display("FAIL single_done_cycle: got %0d, required 18", n);
      end
      @(negedge clk);
      n_chk++;
      if ({s_done, s_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_done_pulse: got done=%b busy=%b, required 0 0", s_done, s_busy);
      end
      n_chk++;
      if (ram_s[0] !== 8'd1 || ram_s[15] !== 8'd1) begin
         n_fail++;
         $display("FAIL single_ends: got ram[0]=%0d ram[15]=%0d, required 1 1", ram_s[0], ram_s[15]);
      end
      mid = 0;
      for (int i = 1; i < 15; i++) if (ram_s[i] !== 8'd0) mid++;
      n_chk++;
      if (mid !== 0) begin
         n_fail++;
         $display("FAIL single_middle: got %0d nonzero pixels, required 0", mid);
      end
      n_chk++;
      if (q_s.size() !== 0) begin
         n_fail++;
         $display("FAIL single_pending: got %0d writes missing, required 0", q_s.size());
      end
   endtask

   // Full Geometry load with a 5-cycle hold at word 3 k=7 and a stray start at word 10.
   task automatic test_hold_and_busy_start();
      int n, d0, req;
      bit found;
      for (int w = 0; w < 1024; w++) rom[w] = geo_word(w);
      clear_ram();
      q_b.delete();
      push_exp(1024, 1'b0);
      req = exp_cycles(1024) + 5;
      d0 = done_b;
      pulse_b_start();
      fork
         wait_b(n);
         begin
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
               @(negedge clk);
               if (b_sti_rd && b_sti_addr == 10'd3) found = 1'b1;
            end
            n_chk++;
            if (!found) begin
               n_fail++;
               $display("FAIL hold_trigger: got no fetch of word 3, required one within 200 cycles");
            end
            repeat (8) @(posedge clk);
            #1 b_hold = 1'b1;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               n_chk++;
               if (b_res_wr !== 1'b0 || b_res_addr !== 14'd55) begin
                  n_fail++;
                  $display("FAIL hold_stall: got wr=%b addr=%0d, required wr=0 addr=55", b_res_wr, b_res_addr);
               end
            end
            @(posedge clk); #1 b_hold = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 400 && !found; i++) begin
               @(negedge clk);
               if (b_sti_rd && b_sti_addr == 10'd10) found = 1'b1;
            end
            @(posedge clk); #1 b_start = 1'b1;
            @(posedge clk); #1 b_start = 1'b0;
         end
      join
      n_chk++;
      if (n !== req) begin
         n_fail++;
         $display("FAIL full_done_cycle: got %0d, required %0d", n, req);
      end
      n_chk++;
      if (b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_busy_at_done: got %b, required 0", b_busy);
      end
      @(negedge clk);
      n_chk++;
      if ({b_done, b_busy} !== 2'b00 || done_b - d0 !== 1) begin
         n_fail++;
         $display("FAIL full_done_once: got done=%b busy=%b pulses=%0d, required 0 0 1", b_done, b_busy, done_b - d0);
      end
      n_chk++;
      if (wcnt_b[55] !== 1) begin
         n_fail++;
         $display("FAIL hold_pixel55: got %0d writes, required 1", wcnt_b[55]);
      end
      n_chk++;
      if (ram_errs_b() !== 0 || q_b.size() !== 0) begin
         n_fail++;
         $display("FAIL full_ram: got %0d bad pixels %0d missing writes, required 0 0", ram_errs_b(), q_b.size());
      end
   endtask

   task automatic test_reset_midload();
      int n, d0, req;
      bit found;
      for (int w = 0; w < 1024; w++) rom[w] = 16'(w) ^ 16'h5A5A;
      clear_ram();
      q_b.delete();
      push_exp(1024, 1'b0);
      d0 = done_b;
      pulse_b_start();
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (b_sti_rd && b_sti_addr == 10'd100) found = 1'b1;
      end
      n_chk++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_trigger: got no fetch of word 100, required one");
      end
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      q_b.delete();
      @(negedge clk);
      n_chk++;
      if ({b_res_wr, b_sti_rd} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_abort: got wr=%b rd=%b, required 0 0", b_res_wr, b_sti_rd);
      end
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_chk++;
         if ({b_busy, b_done, b_sti_rd, b_res_wr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_quiet: got busy=%b done=%b rd=%b wr=%b, required 0000",
                     b_busy, b_done, b_sti_rd, b_res_wr);
         end
      end
      n_chk++;
      if (done_b !== d0) begin
         n_fail++;
         $display("FAIL reset_no_done: got %0d pulses, required 0", done_b - d0);
      end
      for (int w = 0; w < 1024; w++) rom[w] = geo_word(w);
      clear_ram();
      push_exp(1024, 1'b0);
      req = exp_cycles(1024);
      pulse_b_start();
      wait_b(n);
      n_chk++;
      if (n !== req) begin
         n_fail++;
         $display("FAIL reload_done_cycle: got %0d, required %0d", n, req);
      end
      @(negedge clk);
      n_chk++;
      if (ram_errs_b() !== 0 || q_b.size() !== 0 || done_b - d0 !== 1) begin
         n_fail++;
         $display("FAIL reload_ram: got %0d bad pixels %0d missing %0d pulses, required 0 0 1",
                  ram_errs_b(), q_b.size(), done_b - d0);
      end
   endtask

   task automatic test_skip_zero();
      int n, req, total;
      for (int w = 0; w < 1024; w++) rom[w] = 16'h0000;
      rom[5] = 16'hFFFF;
      clear_ram();
      q_b.delete();
      push_exp(1024, 1'b0);
      req = SKIP ? 1041 : 17409;
      pulse_b_start();
      wait_b(n);
      n_chk++;
      if (n !== req) begin
         n_fail++;
         $display("FAIL sparse_done_cycle: got %0d, required %0d", n, req);
      end
      @(negedge clk);
      total = 0;
      for (int a = 0; a < 16384; a++) total += wcnt_b[a];
      n_chk++;
      if (total !== (SKIP ? 16 : 16384)) begin
         n_fail++;
         $display("FAIL sparse_write_count: got %0d, required %0d", total, SKIP ? 16 : 16384);
      end
      n_chk++;
      if (ram_errs_b() !== 0 || q_b.size() !== 0) begin
         n_fail++;
         $display("FAIL sparse_ram: got %0d bad pixels %0d missing writes, required 0 0", ram_errs_b(), q_b.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      clr = 1'b0;
      b_start = 1'b1;
      s_start = 1'b1;
      b_hold = 1'b0;
      s_hold = 1'b0;
      for (int w = 0; w < 1024; w++) rom[w] = 16'h0000;
      fork
         monitor();
      join_none
      test_reset();
      test_single_word();
      test_hold_and_busy_start();
      test_reset_midload();
      test_skip_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
